dma_stream_scheduler: RTL and testbench

Sequential stream scheduler for the multi-stream DMA. It picks one eligible stream by programmed priority level, with round-robin among equal levels. It then locks the shared AHB master datapath to that stream for a bounded burst of beats and releases it on burst end, on stream drain or on disable. The scheduler sits between the per-stream FIFO/control logic and the AHB master sequencer.

---
 rtl/dma_stream_scheduler.sv | 127 ++++++++++++
 tb/tb_dma_stream_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_stream_scheduler.sv
// dma_stream_scheduler: priority arbiter that locks the AHB datapath to one stream per bounded burst.
// Optional DMA_SCHED_RR_EN: round-robin tie-break within a priority level (default: lowest index wins).
module dma_stream_scheduler #(
    parameter int NUMB_CH     = 4,
    parameter int SIZE_EXP    = 5,
    parameter int BURST_BEATS = 4,
    localparam int SEL_W      = (NUMB_CH > 1) ? $clog2(NUMB_CH) : 1,
    localparam int LB_W       = SIZE_EXP + 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NUMB_CH-1:0]      i_en_stream,
    input  logic [2*NUMB_CH-1:0]    i_pl,
    input  logic [NUMB_CH-1:0]      i_requests,
    input  logic                    i_relevance_req,
    input  logic [LB_W*NUMB_CH-1:0] i_left_bytes,
    input  logic                    i_beat_done,
    output logic                    o_grant_valid,
    output logic                    o_grant_start,
    output logic [SEL_W-1:0]        o_stream_sel
);
    localparam int CNT_W = $clog2(BURST_BEATS) + 1;

    typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

    state_t             r_state, w_next;
    logic [NUMB_CH-1:0] w_elig;
    logic               w_any, w_found, w_release;
    logic [1:0]         w_max;
    logic [SEL_W-1:0]   w_win, w_start, r_sel;
    logic [CNT_W-1:0]   r_cnt, w_cnt_inc;
    logic               r_valid, r_start;
    int                 w_idx;

    always_comb begin
        for (int c = 0; c < NUMB_CH; c++)
            w_elig[c] = i_en_stream[c] && (i_left_bytes[c*LB_W +: LB_W] != '0) &&
                        (i_requests[c] || i_relevance_req);
    end

    always_comb begin
        w_any = 1'b0;
        w_max = 2'd0;
        for (int c = 0; c < NUMB_CH; c++) begin
            w_any = w_any | w_elig[c];
            if (w_elig[c] && i_pl[2*c +: 2] > w_max)
                w_max = i_pl[2*c +: 2];
        end
    end

`ifdef DMA_SCHED_RR_EN
    logic [SEL_W-1:0] r_rr [4];
    logic [1:0]       r_lvl;

    assign w_start = (r_rr[w_max] == SEL_W'(NUMB_CH - 1)) ? '0 : r_rr[w_max] + SEL_W'(1);

    // Pointer holds the last index granted at each level; reset makes index 0 searched first.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int l = 0; l < 4; l++)
                r_rr[l] <= SEL_W'(NUMB_CH - 1);
            r_lvl <= 2'd0;
        end else if (r_state == IDLE && w_any) begin
            r_lvl <= w_max;
        end else if (r_state == GRANT) begin
            r_rr[r_lvl] <= r_sel;
        end
    end
`else
    assign w_start = '0;
`endif

    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUMB_CH; k++) begin
            w_idx = (int'(w_start) + k) % NUMB_CH;
            if (!w_found && w_elig[w_idx] && i_pl[2*w_idx +: 2] == w_max) begin
                w_win   = SEL_W'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    assign w_cnt_inc = (r_cnt == CNT_W'(BURST_BEATS)) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_release = (i_beat_done && w_cnt_inc == CNT_W'(BURST_BEATS)) ||
                       !i_en_stream[r_sel] || (i_left_bytes[r_sel*LB_W +: LB_W] == '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? GRANT : IDLE;
            GRANT:   w_next = BUSY;
            BUSY:    w_next = w_release ? IDLE : BUSY;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they carry no input-to-output path.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sel   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_start <= 1'b0;
        end else begin
            if (r_state == IDLE && w_any)
                r_sel <= w_win;
            r_cnt   <= (r_state == GRANT) ? '0 :
                       (r_state == BUSY && i_beat_done) ? w_cnt_inc : r_cnt;
            r_valid <= (w_next != IDLE);
            r_start <= (w_next == GRANT);
        end
    end

    assign o_grant_valid = r_valid;
    assign o_grant_start = r_start;
    assign o_stream_sel  = r_sel;
endmodule

// File: tb/tb_dma_stream_scheduler.sv
// tb_dma_stream_scheduler: table vectors, directed corner sequences and randomized traffic
// checked against a transaction-level model of the scheduler.
module tb_dma_stream_scheduler;
    localparam int NCH = 4;
    localparam int LBW = 6;
    localparam int BB  = 4;

    logic             clk  = 1'b0;
    logic             rst  = 1'b1;
    logic [NCH-1:0]   en   = '0;
    logic [NCH-1:0]   req  = '0;
    logic [2*NCH-1:0] pl   = '0;
    logic             rel  = 1'b0;
    logic             beat = 1'b0;
    logic [LBW*NCH-1:0] left = '0;
    logic             o_valid, o_start;
    logic [1:0]       o_sel;

    int n_checks = 0;
    int n_err    = 0;

    // Model: phase 0 = no owner, 1 = grant cycle, 2 = owner moving beats.
    int m_phase, m_sel, m_lvl, m_beats;
    int m_rr [4];

    typedef struct {
        logic [NCH-1:0]     en;
        logic [2*NCH-1:0]   pl;
        logic [NCH-1:0]     req;
        logic [LBW*NCH-1:0] left;
        logic               beat;
        logic               v;
        logic               s;
        logic [1:0]         sel;
    } vec_t;

    vec_t tbl [19];

    always #5 clk = ~clk;

    dma_stream_scheduler #(.NUMB_CH(NCH), .SIZE_EXP(5), .BURST_BEATS(BB)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_en_stream     (en),
        .i_pl            (pl),
        .i_requests      (req),
        .i_relevance_req (rel),
        .i_left_bytes    (left),
        .i_beat_done     (beat),
        .o_grant_valid   (o_valid),
        .o_grant_start   (o_start),
        .o_stream_sel    (o_sel)
    );

    function automatic int pl_of(int c);
        return int'(pl[2*c +: 2]);
    endfunction

    function automatic int left_of(int c);
        return int'(left[LBW*c +: LBW]);
    endfunction

    function automatic bit elig(int c);
        return en[c] && left_of(c) != 0 && (req[c] || rel);
    endfunction

    function automatic vec_t mk(bit e, bit b, bit v, bit s);
        vec_t r;
        r.en   = e ? 4'b0100 : 4'b0000;
        r.req  = 4'b0100;
        r.pl   = 8'h10;
        r.left = 24'h008000;
        r.beat = b;
        r.v    = v;
        r.s    = s;
        r.sel  = 2'd2;
        return r;
    endfunction

    task automatic check(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_sel   = 0;
        m_lvl   = 0;
        m_beats = 0;
        for (int l = 0; l < 4; l++) m_rr[l] = NCH - 1;
    endtask

    // Winner = highest level; within it, the stream closest after the level's last grant.
    task automatic model_step();
        int top, best, bd, d;
        if (m_phase == 0) begin
            top  = -1;
            best = 0;
            bd   = 2 * NCH;
            for (int c = 0; c < NCH; c++)
                if (elig(c) && pl_of(c) > top) top = pl_of(c);
            if (top >= 0) begin
                for (int c = 0; c < NCH; c++) begin
                    if (elig(c) && pl_of(c) == top) begin
`ifdef DMA_SCHED_RR_EN
                        d = (c - m_rr[top] - 1 + 2 * NCH) % NCH;
`else
                        d = c;
`endif
                        if (d < bd) begin
                            bd   = d;
                            best = c;
                        end
                    end
                end
                m_sel   = best;
                m_lvl   = top;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_rr[m_lvl] = m_sel;
            m_beats     = 0;
            m_phase     = 2;
        end else begin
            if (beat) m_beats++;
            if (m_beats >= BB || !en[m_sel] || left_of(m_sel) == 0) m_phase = 0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("model_valid", int'(o_valid), (m_phase != 0) ? 1 : 0);
        check("model_start", int'(o_start), (m_phase == 1) ? 1 : 0);
        check("model_sel", int'(o_sel), m_sel);
    endtask

    task automatic set_ch(int c, bit e, int p, bit r, int l);
        en[c]             = e;
        pl[2*c +: 2]      = 2'(p);
        req[c]            = r;
        left[LBW*c +: LBW] = LBW'(l);
    endtask

    task automatic clear_all();
        en   = '0;
        req  = '0;
        pl   = '0;
        left = '0;
        rel  = 1'b0;
        beat = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        beat = 1'b0;
        #1;
        check("rst_valid", int'(o_valid), 0);
        check("rst_start", int'(o_start), 0);
        check("rst_sel", int'(o_sel), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_start(string nm, int exp_sel);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!o_start && n < 10);
        check({nm, "_start_seen"}, int'(o_start), 1);
        check({nm, "_sel"}, int'(o_sel), exp_sel);
    endtask

    task automatic burst(string nm, int exp_sel);
        int n = 0;
        wait_start(nm, exp_sel);
        beat = 1'b1;
        do begin
            cycle();
            n++;
        end while (o_valid && n < 12);
        beat = 1'b0;
        check({nm, "_beats"}, n - 1, BB);
    endtask

    initial begin
        int rr_exp [4];
        tbl[0]  = mk(1, 0, 1, 1);
        tbl[1]  = mk(1, 0, 1, 0);
        tbl[2]  = mk(1, 1, 1, 0);
        tbl[3]  = mk(1, 1, 1, 0);
        tbl[4]  = mk(1, 1, 1, 0);
        tbl[5]  = mk(1, 1, 0, 0);
        tbl[6]  = mk(1, 0, 1, 1);
        tbl[7]  = mk(1, 1, 1, 0);
        tbl[8]  = mk(1, 1, 1, 0);
        tbl[9]  = mk(1, 1, 1, 0);
        tbl[10] = mk(1, 1, 1, 0);
        tbl[11] = mk(1, 1, 0, 0);
        tbl[12] = mk(0, 1, 0, 0);
        tbl[13] = mk(1, 1, 1, 1);
        tbl[14] = mk(1, 0, 1, 0);
        tbl[15] = mk(1, 1, 1, 0);
        tbl[16] = mk(1, 1, 1, 0);
        tbl[17] = mk(1, 1, 1, 0);
        tbl[18] = mk(1, 1, 0, 0);
        model_reset();

        do_reset();
        for (int i = 0; i < 19; i++) begin
            en   = tbl[i].en;
            pl   = tbl[i].pl;
            req  = tbl[i].req;
            left = tbl[i].left;
            beat = tbl[i].beat;
            cycle();
            check($sformatf("tbl%0d_valid", i), int'(o_valid), int'(tbl[i].v));
            check($sformatf("tbl%0d_start", i), int'(o_start), int'(tbl[i].s));
            check($sformatf("tbl%0d_sel", i), int'(o_sel), int'(tbl[i].sel));
        end

        clear_all();
        do_reset();
        set_ch(0, 1, 0, 1, 8);
        set_ch(3, 1, 3, 1, 8);
        burst("prio_hi", 3);
        burst("prio_hi_again", 3);
        en[3] = 1'b0;
        burst("prio_lo", 0);

        clear_all();
        do_reset();
        set_ch(0, 1, 2, 1, 16);
        set_ch(1, 1, 2, 1, 16);
        set_ch(2, 1, 2, 1, 16);
`ifdef DMA_SCHED_RR_EN
        rr_exp = '{0, 1, 2, 0};
`else
        rr_exp = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) burst($sformatf("rr%0d", i), rr_exp[i]);

        clear_all();
        cycle();
        set_ch(1, 1, 1, 1, 8);
        wait_start("drain", 1);
        beat = 1'b1;
        repeat (3) cycle();
        check("drain_busy", int'(o_valid), 1);
        beat = 1'b0;
        set_ch(1, 1, 1, 1, 0);
        cycle();
        check("drain_release", int'(o_valid), 0);
        repeat (4) begin
            cycle();
            check("drain_no_regrant", int'(o_valid), 0);
        end

        set_ch(1, 1, 1, 1, 8);
        wait_start("dis", 1);
        beat = 1'b1;
        repeat (2) cycle();
        en[1] = 1'b0;
        cycle();
        check("dis_release", int'(o_valid), 0);
        beat = 1'b0;
        cycle();
        check("dis_single_valid", int'(o_valid), 0);
        check("dis_single_start", int'(o_start), 0);
        en[1] = 1'b1;
        burst("dis_regrant", 1);

        clear_all();
        do_reset();
        set_ch(0, 1, 1, 1, 8);
        set_ch(1, 1, 2, 1, 8);
        set_ch(3, 1, 2, 1, 8);
        wait_start("mid_first", 1);
        beat = 1'b1;
        repeat (4) cycle();
        check("mid_busy", int'(o_valid), 1);
        beat = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(o_valid), 0);
        check("mid_rst_start", int'(o_start), 0);
        check("mid_rst_sel", int'(o_sel), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        wait_start("mid_regrant", 1);

        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(9) == 0) en[c] = ~en[c];
                if ($urandom_range(7) == 0) pl[2*c +: 2] = 2'($urandom_range(3));
                if ($urandom_range(3) == 0) req[c] = ~req[c];
                if ($urandom_range(11) == 0)
                    left[LBW*c +: LBW] = ($urandom_range(3) == 0) ? '0 : LBW'($urandom_range(63));
            end
            rel  = ($urandom_range(15) == 0);
            beat = ($urandom_range(1) == 1);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
